// File: rtl/logic_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// logic_sweep_ctrl
//
// Sweeps all eight input vectors of a 3-input combinational circuit, holds
// each vector for a programmable number of cycles, samples the returned F
// at the end of each hold, and compares the captured truth table against a
// golden value.
//
// Ports
//   clk       in   1        single clock, rising edge
//   rst_n     in   1        asynchronous active-low reset
//   start     in   1        one-cycle sweep request (accepted in IDLE only)
//   abort     in   1        synchronous cancel of a running sweep
//   dwell     in   DWELL_W  hold cycles per vector (0 treated as 1)
//   expected  in   8        golden truth table, bit i = F for {A,B,C}=i
//   abc       out  3        {A,B,C} to the circuit under test (registered)
//   f_in      in   1        F returned by the circuit under test
//   busy      out  1        high while a sweep is running
//   done      out  1        one-cycle pulse on sweep completion
//   result    out  8        captured truth table
//   match     out  1        result == latched expected, valid from done
// ----------------------------------------------------------------------------
module logic_sweep_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         expected,
    output logic [2:0]         abc,
    input  logic               f_in,
    output logic               busy,
    output logic               done,
    output logic [7:0]         result,
    output logic               match
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [2:0]         abc_reg,    abc_next;
    logic [DWELL_W-1:0] cnt_reg,    cnt_next;
    logic [DWELL_W-1:0] d_reg,      d_next;
    logic [7:0]         exp_reg,    exp_next;
    logic [7:0]         result_reg, result_next;
    logic               match_reg,  match_next;

    // A zero dwell would make the down-counter underflow; hold for one cycle instead.
    logic [DWELL_W-1:0] dwell_eff;
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            abc_reg    <= '0;
            cnt_reg    <= '0;
            d_reg      <= '0;
            exp_reg    <= '0;
            result_reg <= '0;
            match_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            abc_reg    <= abc_next;
            cnt_reg    <= cnt_next;
            d_reg      <= d_next;
            exp_reg    <= exp_next;
            result_reg <= result_next;
            match_reg  <= match_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        abc_next    = abc_reg;
        cnt_next    = cnt_reg;
        d_next      = d_reg;
        exp_next    = exp_reg;
        result_next = result_reg;
        match_next  = match_reg;

        case (state_reg)
            IDLE: begin
                // abort has priority over a coincident start
                if (start && !abort) begin
                    d_next      = dwell_eff;
                    cnt_next    = dwell_eff - DWELL_W'(1);
                    exp_next    = expected;
                    result_next = '0;
                    match_next  = 1'b0;
                    abc_next    = 3'd0;
                    state_next  = RUN;
                end
            end

            RUN: begin
                if (abort) begin
                    // Keep already-sampled bits; the pending sample is dropped.
                    state_next = IDLE;
                    abc_next   = 3'd0;
                    cnt_next   = '0;
                    match_next = 1'b0;
                end else if (cnt_reg == '0) begin
                    result_next[abc_reg] = f_in;
                    cnt_next             = d_reg - DWELL_W'(1);
                    if (abc_reg == 3'd7) begin
                        // Compare against the table including the bit written now,
                        // so match is already valid during the done cycle.
                        state_next = DONE;
                        abc_next   = 3'd0;
                        match_next = (result_next == exp_reg);
                    end else begin
                        abc_next = abc_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign abc    = abc_reg;
    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign match  = match_reg;

endmodule
